// File: rtl/axis_sync_fifo_pkg.sv
// Shared defaults for the AXI4-Stream FIFO slice.
// A stored beat is packed as {tlast, tdata}, so tlast always sits in the MSB.
package axis_sync_fifo_pkg;

    localparam int AXIS_DATA_WIDTH_DEFAULT = 8;
    localparam int AXIS_FIFO_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI4-Stream beat bundle; modports are named from the point of view of the
// block that owns each end of the link.
interface axis_sync_fifo_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/axis_sync_fifo_mem.sv
// Beat storage for the FIFO: synchronous write, asynchronous read, no reset.
// Read is combinational so the head entry falls through to the output port.
module axis_fifo_mem #(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH:0]   wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH:0]   rdata
);

    logic [DATA_WIDTH:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO with tlast, occupancy
// and complete-packet counters. Storage lives in axis_fifo_mem.
module axis_sync_fifo
    import axis_sync_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = AXIS_DATA_WIDTH_DEFAULT,
    parameter  int DEPTH      = AXIS_FIFO_DEPTH_DEFAULT,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    axis_sync_fifo_if.slave     s_axis,
    axis_sync_fifo_if.master    m_axis,
    output logic [ADDR_WIDTH:0] fill_count,
    output logic [ADDR_WIDTH:0] pkt_count,
    output logic                full,
    output logic                empty
);

    typedef logic [ADDR_WIDTH:0] ptr_t;
    localparam ptr_t PTR_ONE = ptr_t'(1);

    ptr_t wr_ptr;
    ptr_t rd_ptr;
    ptr_t wr_ptr_next;
    ptr_t rd_ptr_next;

    logic                ready_en;
    logic                do_write;
    logic                do_read;
    logic                pkt_inc;
    logic                pkt_dec;
    logic [DATA_WIDTH:0] wr_beat;
    logic [DATA_WIDTH:0] rd_beat;

    // Both valids come from registered state only, never from the far side's ready.
    assign s_axis.tready = ready_en & ~full;
    assign m_axis.tvalid = ~empty;

    assign do_write = s_axis.tvalid & s_axis.tready;
    assign do_read  = m_axis.tvalid & m_axis.tready;

    assign wr_beat = {s_axis.tlast, s_axis.tdata};

    assign m_axis.tdata = empty ? '0 : rd_beat[DATA_WIDTH-1:0];
    assign m_axis.tlast = ~empty & rd_beat[DATA_WIDTH];

    assign pkt_inc = do_write & s_axis.tlast;
    assign pkt_dec = do_read & m_axis.tlast;

    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        if (do_write) begin
            wr_ptr_next = wr_ptr + PTR_ONE;
        end
        if (do_read) begin
            rd_ptr_next = rd_ptr + PTR_ONE;
        end
    end

    // Ready is held off for one cycle after reset release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Flags are computed from the next pointers so they are registered yet exact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            empty  <= (wr_ptr_next == rd_ptr_next);
            full   <= (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]) &&
                      (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_count <= '0;
        end else begin
            case ({do_write, do_read})
                2'b10:   fill_count <= fill_count + PTR_ONE;
                2'b01:   fill_count <= fill_count - PTR_ONE;
                default: fill_count <= fill_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pkt_count <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count <= pkt_count + PTR_ONE;
                2'b01:   pkt_count <= pkt_count - PTR_ONE;
                default: pkt_count <= pkt_count;
            endcase
        end
    end

    axis_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (rd_beat)
    );

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Directed bench for axis_sync_fifo: a vector table for single-beat behaviour
// plus hand-written sequences for full, streaming and asynchronous reset.
module tb_axis_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [AW:0]   fill_count;
    logic [AW:0]   pkt_count;
    logic          full;
    logic          empty;

    int checks   = 0;
    int failures = 0;

    logic [8:0] model_q[$];

    axis_sync_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    axis_sync_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    axis_sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .fill_count (fill_count),
        .pkt_count  (pkt_count),
        .full       (full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic [4:0] fill;
        logic [4:0] pkt;
        logic       full;
        logic       empty;
        logic       sready;
    } exp_t;

    typedef struct {
        logic       s_valid;
        logic [7:0] s_data;
        logic       s_last;
        logic       m_ready;
        exp_t       exp;
    } vec_t;

    function automatic exp_t mkExp(logic v, logic [7:0] d, logic l, logic [4:0] f,
                                   logic [4:0] p, logic fu, logic em, logic sr);
        exp_t e;
        e.valid = v; e.data = d; e.last = l; e.fill = f;
        e.pkt = p; e.full = fu; e.empty = em; e.sready = sr;
        return e;
    endfunction

    function automatic vec_t mkVec(logic sv, logic [7:0] sd, logic sl, logic mr, exp_t e);
        vec_t v;
        v.s_valid = sv; v.s_data = sd; v.s_last = sl; v.m_ready = mr; v.exp = e;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkState(string tag, exp_t e);
        checkOutput({tag, " m_tvalid"},   32'(m_if.tvalid), 32'(e.valid));
        checkOutput({tag, " m_tdata"},    32'(m_if.tdata),  32'(e.data));
        checkOutput({tag, " m_tlast"},    32'(m_if.tlast),  32'(e.last));
        checkOutput({tag, " fill_count"}, 32'(fill_count),  32'(e.fill));
        checkOutput({tag, " pkt_count"},  32'(pkt_count),   32'(e.pkt));
        checkOutput({tag, " full"},       32'(full),        32'(e.full));
        checkOutput({tag, " empty"},      32'(empty),       32'(e.empty));
        checkOutput({tag, " s_tready"},   32'(s_if.tready), 32'(e.sready));
    endtask

    task automatic applyStimulus(logic sv, logic [7:0] sd, logic sl, logic mr);
        s_if.tvalid = sv;
        s_if.tdata  = sd;
        s_if.tlast  = sl;
        m_if.tready = mr;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Drains the model queue through the DUT, checking every beat in order.
    task automatic drainModel(string tag);
        logic [8:0] beat;
        int n;
        n = 0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        while (model_q.size() > 0) begin
            #1;
            beat = model_q.pop_front();
            checkOutput($sformatf("%s beat%0d tvalid", tag, n), 32'(m_if.tvalid), 32'd1);
            checkOutput($sformatf("%s beat%0d tdata", tag, n),  32'(m_if.tdata),  32'(beat[7:0]));
            checkOutput($sformatf("%s beat%0d tlast", tag, n),  32'(m_if.tlast),  32'(beat[8]));
            stepClock();
            n++;
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkState({tag, " drained"}, mkExp(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1));
    endtask

    initial begin
        vec_t vecs[10];
        exp_t idle;
        exp_t rst_exp;
        logic [7:0] v;

        idle    = mkExp(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        rst_exp = mkExp(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

        // inputs applied this cycle, expected outputs seen before the edge
        vecs[0] = mkVec(1'b1, 8'hA5, 1'b1, 1'b0, idle);
        vecs[1] = mkVec(1'b0, 8'h00, 1'b0, 1'b0, mkExp(1'b1, 8'hA5, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1));
        vecs[2] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, mkExp(1'b1, 8'hA5, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1));
        vecs[3] = mkVec(1'b0, 8'h00, 1'b0, 1'b0, idle);
        vecs[4] = mkVec(1'b1, 8'h3C, 1'b0, 1'b1, idle);
        vecs[5] = mkVec(1'b1, 8'h5A, 1'b1, 1'b1, mkExp(1'b1, 8'h3C, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1));
        vecs[6] = mkVec(1'b1, 8'h77, 1'b0, 1'b1, mkExp(1'b1, 8'h5A, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1));
        vecs[7] = mkVec(1'b0, 8'h00, 1'b0, 1'b0, mkExp(1'b1, 8'h77, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1));
        vecs[8] = mkVec(1'b0, 8'h00, 1'b0, 1'b1, mkExp(1'b1, 8'h77, 1'b0, 5'd1, 5'd0, 1'b0, 1'b0, 1'b1));
        vecs[9] = mkVec(1'b0, 8'h00, 1'b0, 1'b0, idle);

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        $display("[TB] reset phase");
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkState($sformatf("in_reset%0d", i), rst_exp);
        end
        reset = 1'b1;
        #1;
        checkState("reset_release", rst_exp);
        stepClock();

        $display("[TB] vector table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].s_valid, vecs[i].s_data, vecs[i].s_last, vecs[i].m_ready);
            #1;
            checkState($sformatf("vec%0d", i), vecs[i].exp);
            stepClock();
        end

        $display("[TB] fill to full");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(i), (i == 7) || (i == 15), 1'b0);
            model_q.push_back({((i == 7) || (i == 15)) ? 1'b1 : 1'b0, 8'(i)});
            stepClock();
        end
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        #1;
        checkState("full", mkExp(1'b1, 8'h00, 1'b0, 5'd16, 5'd2, 1'b1, 1'b0, 1'b0));
        stepClock();
        checkState("full_reject", mkExp(1'b1, 8'h00, 1'b0, 5'd16, 5'd2, 1'b1, 1'b0, 1'b0));
        drainModel("fill");

        $display("[TB] full plus read");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), (i == 15), 1'b0);
            model_q.push_back({(i == 15) ? 1'b1 : 1'b0, 8'(8'h10 + i)});
            stepClock();
        end
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b1);
        #1;
        checkState("fr_full", mkExp(1'b1, 8'h10, 1'b0, 5'd16, 5'd1, 1'b1, 1'b0, 1'b0));
        stepClock();
        void'(model_q.pop_front());
        checkState("fr_freed", mkExp(1'b1, 8'h11, 1'b0, 5'd15, 5'd1, 1'b0, 1'b0, 1'b1));
        applyStimulus(1'b1, 8'h80, 1'b1, 1'b0);
        stepClock();
        model_q.push_back({1'b1, 8'h80});
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkState("fr_refull", mkExp(1'b1, 8'h11, 1'b0, 5'd16, 5'd2, 1'b1, 1'b0, 1'b0));
        drainModel("fr");

        $display("[TB] streaming");
        for (int k = 0; k < 5; k++) begin
            v = 8'(8'h40 + k);
            applyStimulus(1'b1, v, v[1:0] == 2'b11, 1'b0);
            model_q.push_back({v[1:0] == 2'b11, v});
            stepClock();
        end
        for (int k = 0; k < 40; k++) begin
            logic [8:0] head;
            v = 8'(8'h45 + k);
            applyStimulus(1'b1, v, v[1:0] == 2'b11, 1'b1);
            #1;
            head = model_q.pop_front();
            checkOutput($sformatf("stream%0d fill_count", k), 32'(fill_count), 32'd5);
            checkOutput($sformatf("stream%0d tdata", k), 32'(m_if.tdata), 32'(head[7:0]));
            checkOutput($sformatf("stream%0d tlast", k), 32'(m_if.tlast), 32'(head[8]));
            model_q.push_back({v[1:0] == 2'b11, v});
            stepClock();
        end
        drainModel("stream");

        $display("[TB] mid-packet reset");
        applyStimulus(1'b1, 8'h61, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 8'h62, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b1, 8'h63, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkState("pre_reset", mkExp(1'b1, 8'h61, 1'b1, 5'd3, 5'd1, 1'b0, 1'b0, 1'b1));
        #2;
        reset = 1'b0;
        #1;
        checkState("async_reset", rst_exp);
        stepClock();
        stepClock();
        checkState("held_reset", rst_exp);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        #1;
        checkState("post_release", rst_exp);
        stepClock();
        for (int k = 0; k < 3; k++) begin
            #1;
            checkState($sformatf("no_stale%0d", k), idle);
            stepClock();
        end
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        #1;
        checkState("fresh_beat", mkExp(1'b1, 8'h99, 1'b1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
